// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, opcode width and FSM states.
package alu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
    localparam logic [OP_W-1:0] OP_OR   = 3'd3;
    localparam logic [OP_W-1:0] OP_AND  = 3'd4;
    localparam logic [OP_W-1:0] OP_LAST = OP_AND;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } state_t;

    // Legal opcodes run from OP_ADD to OP_LAST; higher encodings are rejected before reaching the ALU.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op <= OP_LAST);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO holding packed {op, a, b, acc} entries for the sequencer.
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [OP_W-1:0]          push_op,
    input  logic [WIDTH-1:0]         push_a,
    input  logic [WIDTH-1:0]         push_b,
    input  logic                     push_acc,
    input  logic                     pop,
    output logic [OP_W-1:0]          head_op,
    output logic [WIDTH-1:0]         head_a,
    output logic [WIDTH-1:0]         head_b,
    output logic                     head_acc,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = OP_W + 2 * WIDTH + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef logic [ENTRY_W-1:0] entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    entry_t             push_entry;

    assign push_entry = {push_op, push_a, push_b, push_acc};
    assign {head_op, head_a, head_b, head_acc} = mem_q[rd_ptr_q];

    assign full  = (level_q == FULL_LVL);
    assign empty = (level_q == '0);
    assign level = level_q;

    // Next-state for storage, pointers and occupancy; simultaneous push and pop keeps the level.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Register the FIFO state; reset empties it and clears stored entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 8-bit ALU: queues commands, drives registered operands,
// captures the ALU result into a handshaked output register and keeps an accumulator.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [OP_W-1:0]          cmd_op,
    input  logic [WIDTH-1:0]         cmd_a,
    input  logic [WIDTH-1:0]         cmd_b,
    input  logic                     cmd_acc,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [OP_W-1:0]          alu_op,
    input  logic [WIDTH-1:0]         alu_out,
    input  logic                     alu_carry,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic                     res_carry,
    output logic                     res_err,
    output logic [$clog2(DEPTH):0]   cmd_level
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [OP_W-1:0]    alu_op_q, alu_op_d;
    logic               res_valid_q, res_valid_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;
    logic               res_carry_q, res_carry_d;
    logic               res_err_q, res_err_d;
    logic [WIDTH-1:0]   acc_q, acc_d;

    logic               fifo_full, fifo_empty;
    logic               push, pop, take;
    logic [OP_W-1:0]    head_op;
    logic [WIDTH-1:0]   head_a, head_b;
    logic               head_acc;

    // Ready comes from the registered full flag and is held low during reset.
    assign cmd_ready = !rst && !fifo_full;
    assign push      = cmd_valid && cmd_ready;

    alu_cmd_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_op  (cmd_op),
        .push_a   (cmd_a),
        .push_b   (cmd_b),
        .push_acc (cmd_acc),
        .pop      (pop),
        .head_op  (head_op),
        .head_a   (head_a),
        .head_b   (head_b),
        .head_acc (head_acc),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (cmd_level)
    );

    // FSM next-state: pop from IDLE or on result consumption, issue legal ops, flag illegal ones.
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;
        res_err_d   = res_err_q;
        acc_d       = acc_q;
        take        = 1'b0;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                take = !fifo_empty;
            end
            EXEC: begin
                res_data_d  = alu_out;
                res_carry_d = alu_carry;
                res_err_d   = 1'b0;
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (!res_err_q) begin
                        acc_d = res_data_q;
                    end
                    take    = !fifo_empty;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // acc_d already reflects a result consumed on this same edge.
        if (take) begin
            pop = 1'b1;
            if (op_is_legal(head_op)) begin
                alu_a_d  = head_acc ? acc_d : head_a;
                alu_b_d  = head_b;
                alu_op_d = head_op;
                state_d  = EXEC;
            end else begin
                res_data_d  = '0;
                res_carry_d = 1'b0;
                res_err_d   = 1'b1;
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
        end
    end

    // Register FSM state and all outputs; reset clears everything and drops held results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= OP_ADD;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_err_q   <= 1'b0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
            res_err_q   <= res_err_d;
            acc_q       <= acc_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a simple 8-bit ALU attached.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_a = 8'h00;
    logic [7:0] cmd_b = 8'h00;
    logic       cmd_acc = 1'b0;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic       res_carry;
    logic       res_err;
    logic [2:0] cmd_level;

    int checks   = 0;
    int failures = 0;

    alu_cmd_sequencer #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_acc   (cmd_acc),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_carry (res_carry),
        .res_err   (res_err),
        .cmd_level (cmd_level)
    );

    always #5 clk = ~clk;

    // Reference ALU: add carries out, sub reports the borrow, logic ops clear carry.
    always_comb begin
        alu_out   = 8'h00;
        alu_carry = 1'b0;
        case (alu_op)
            3'd0: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1: {alu_carry, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
            3'd2: alu_out = alu_a ^ alu_b;
            3'd3: alu_out = alu_a | alu_b;
            3'd4: alu_out = alu_a & alu_b;
            default: alu_out = 8'h00;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic acc);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_acc   = acc;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL send_ready: cmd_ready=%b expected 1 within 20 cycles", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 0", cmd_ready); end
        checks++;
        if (res_valid !== 1'b0 || res_data !== 8'h00 || res_err !== 1'b0 || res_carry !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_res: valid=%b data=%h err=%b carry=%b expected all 0", res_valid, res_data, res_err, res_carry);
        end
        checks++;
        if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_op !== 3'd0 || cmd_level !== 3'd0) begin
            failures++;
            $display("[TB] FAIL reset_regs: alu_a=%h alu_b=%h alu_op=%0d level=%0d expected 0", alu_a, alu_b, alu_op, cmd_level);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL ready_after_reset: got %b expected 1", cmd_ready); end
        tick();
    endtask

    task automatic test_add();
        res_ready = 1'b1;
        send_cmd(3'd0, 8'h3C, 8'h05, 1'b0);
        checks++;
        if (res_valid !== 1'b0) begin failures++; $display("[TB] FAIL add_t1: res_valid=%b expected 0", res_valid); end
        tick();
        checks++;
        if (res_valid !== 1'b0 || alu_a !== 8'h3C || alu_b !== 8'h05 || alu_op !== 3'd0) begin
            failures++;
            $display("[TB] FAIL add_exec: valid=%b alu_a=%h alu_b=%h op=%0d expected 0/3c/05/0", res_valid, alu_a, alu_b, alu_op);
        end
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'h41 || res_err !== 1'b0 || res_carry !== 1'b0) begin
            failures++;
            $display("[TB] FAIL add_result: valid=%b data=%h err=%b carry=%b expected 1/41/0/0", res_valid, res_data, res_err, res_carry);
        end
        tick();
        checks++;
        if (res_valid !== 1'b0) begin failures++; $display("[TB] FAIL add_consumed: res_valid=%b expected 0", res_valid); end
    endtask

    task automatic test_accumulate();
        res_ready = 1'b1;
        send_cmd(3'd0, 8'hFF, 8'h01, 1'b1);
        tick();
        checks++;
        if (alu_a !== 8'h41) begin failures++; $display("[TB] FAIL acc_operand: alu_a=%h expected 41", alu_a); end
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'h42 || res_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL acc_add: valid=%b data=%h err=%b expected 1/42/0", res_valid, res_data, res_err);
        end
        tick();
        send_cmd(3'd4, 8'hFF, 8'h0F, 1'b1);
        tick();
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'h02) begin
            failures++;
            $display("[TB] FAIL acc_and: valid=%b data=%h expected 1/02", res_valid, res_data);
        end
        tick();
    endtask

    task automatic test_sub();
        res_ready = 1'b1;
        send_cmd(3'd1, 8'h10, 8'h20, 1'b0);
        tick();
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'hF0 || res_err !== 1'b0 || res_carry !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sub_wrap: valid=%b data=%h err=%b carry=%b expected 1/f0/0/1", res_valid, res_data, res_err, res_carry);
        end
        tick();
    endtask

    task automatic test_illegal();
        res_ready = 1'b1;
        send_cmd(3'b110, 8'h12, 8'h34, 1'b0);
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'h00 || res_err !== 1'b1 || res_carry !== 1'b0) begin
            failures++;
            $display("[TB] FAIL illegal_result: valid=%b data=%h err=%b carry=%b expected 1/00/1/0", res_valid, res_data, res_err, res_carry);
        end
        checks++;
        if (alu_op !== 3'd1 || alu_a !== 8'h10 || alu_b !== 8'h20) begin
            failures++;
            $display("[TB] FAIL illegal_alu_held: op=%0d a=%h b=%h expected 1/10/20", alu_op, alu_a, alu_b);
        end
        tick();
        send_cmd(3'd0, 8'h99, 8'h00, 1'b1);
        tick();
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'hF0 || res_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL illegal_acc_kept: valid=%b data=%h err=%b expected 1/f0/0", res_valid, res_data, res_err);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops  [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        logic [7:0] as   [6] = '{8'h01, 8'h05, 8'hFF, 8'hA0, 8'hCC, 8'h80};
        logic [7:0] bs   [6] = '{8'h02, 8'h03, 8'h0F, 8'h05, 8'hAA, 8'h80};
        logic [7:0] exps [5] = '{8'h03, 8'h02, 8'hF0, 8'hA5, 8'h88};
        int idx = 0;
        int last_cyc = 0;
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_cmd(ops[i], as[i], bs[i], 1'b0);
        end
        cmd_valid = 1'b1;
        cmd_op    = ops[5];
        cmd_a     = as[5];
        cmd_b     = bs[5];
        cmd_acc   = 1'b0;
        tick();
        tick();
        checks++;
        if (cmd_ready !== 1'b0 || cmd_level !== 3'd4) begin
            failures++;
            $display("[TB] FAIL full: cmd_ready=%b level=%0d expected 0/4", cmd_ready, cmd_level);
        end
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'h03) begin
            failures++;
            $display("[TB] FAIL full_hold: valid=%b data=%h expected 1/03", res_valid, res_data);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int c = 0; c < 30 && idx < 5; c++) begin
            if (res_valid === 1'b1) begin
                checks++;
                if (res_data !== exps[idx] || res_err !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL drain_data[%0d]: data=%h err=%b expected %h/0", idx, res_data, res_err, exps[idx]);
                end
                if (idx > 0) begin
                    checks++;
                    if (c - last_cyc != 2) begin
                        failures++;
                        $display("[TB] FAIL drain_spacing[%0d]: gap=%0d expected 2", idx, c - last_cyc);
                    end
                end
                last_cyc = c;
                idx++;
            end
            tick();
        end
        checks++;
        if (idx != 5) begin failures++; $display("[TB] FAIL drain_count: got %0d expected 5", idx); end
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || cmd_level !== 3'd0 || res_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drain_end: ready=%b level=%0d valid=%b expected 1/0/0", cmd_ready, cmd_level, res_valid);
        end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        res_ready = 1'b0;
        send_cmd(3'd2, 8'h0F, 8'hF0, 1'b0);
        send_cmd(3'd3, 8'h11, 8'h22, 1'b0);
        send_cmd(3'd1, 8'h09, 8'h01, 1'b0);
        send_cmd(3'd0, 8'h20, 8'h30, 1'b0);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'hFF || cmd_level !== 3'd3) begin
            failures++;
            $display("[TB] FAIL mid_setup: valid=%b data=%h level=%0d expected 1/ff/3", res_valid, res_data, cmd_level);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || alu_op !== 3'd3 || cmd_level !== 3'd2) begin
            failures++;
            $display("[TB] FAIL mid_exec: valid=%b op=%0d level=%0d expected 0/3/2", res_valid, alu_op, cmd_level);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (res_valid !== 1'b0 || cmd_level !== 3'd0 || alu_op !== 3'd0 || alu_a !== 8'h00 || res_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL mid_reset: valid=%b level=%0d op=%0d a=%h data=%h expected 0/0/0/00/00", res_valid, cmd_level, alu_op, alu_a, res_data);
        end
        rst = 1'b0;
        res_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (res_valid === 1'b1 || cmd_level !== 3'd0) stale++;
        end
        checks++;
        if (stale != 0) begin failures++; $display("[TB] FAIL mid_stale: %0d cycles with activity expected 0", stale); end
        send_cmd(3'd0, 8'h77, 8'h05, 1'b1);
        tick();
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'h05) begin
            failures++;
            $display("[TB] FAIL mid_acc_cleared: valid=%b data=%h expected 1/05", res_valid, res_data);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_accumulate();
        test_sub();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream issue stage for the 8-bit ALU.
- Accepts operation commands over a valid/ready interface and buffers them in a small FIFO.
- Drives registered operands and opcode into the ALU, then captures the ALU result and carry into an output register with its own valid/ready handshake.
- Supports an accumulate mode that substitutes the last consumed result for operand A, and rejects opcodes the ALU does not define.

Parameters:
- WIDTH, 8: operand and result width.
- DEPTH, 4: command FIFO entries; must be a power of two and at least 2.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- cmd_valid  in  1  Command present.
- cmd_ready  out  1  Command FIFO can accept; equals !full.
- cmd_op  in  3  Opcode: 000 add, 001 sub, 010 xor, 011 or, 100 and; 101-111 illegal.
- cmd_a  in  WIDTH  Operand A.
- cmd_b  in  WIDTH  Operand B.
- cmd_acc  in  1  1 = use the accumulator in place of cmd_a.
- alu_a  out  WIDTH  Registered operand A to the ALU.
- alu_b  out  WIDTH  Registered operand B to the ALU.
- alu_op  out  3  Registered opcode to the ALU.
- alu_out  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_carry  in  1  ALU carry output.
- res_valid  out  1  Result register holds an unconsumed result.
- res_ready  in  1  Downstream accepts the result.
- res_data  out  WIDTH  Result.
- res_carry  out  1  Carry captured alongside res_data.
- res_err  out  1  Result came from an illegal opcode.
- cmd_level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst high at an edge): FIFO emptied, state <= IDLE, all outputs and registers cleared.
  - Cleared values: res_valid/res_data/res_carry/res_err = 0; alu_a/alu_b = 0; alu_op = 000; acc = 0; cmd_level = 0.
  - cmd_ready = 0 while rst is high, and 1 in the first cycle after reset deasserts.
  - In-flight commands and any held result are discarded. Reset has priority over every other event.
- FIFO push: cmd_valid && cmd_ready writes {op, a, b, acc} at the edge.
- FIFO pop: decided only from registered occupancy. A push into an empty FIFO is not popped in the same cycle.
  - Push and pop in the same cycle leave the level unchanged.
  - cmd_ready is derived from registered full, so a push while full cannot occur.
- FSM, three states:
  - IDLE: if FIFO not empty, pop the head.
    - Legal op: alu_a <= (acc_flag ? acc : a), alu_b <= b, alu_op <= op; next state EXEC.
    - Illegal op: res_data <= 0, res_carry <= 0, res_err <= 1, res_valid <= 1; alu_* unchanged; next state HOLD.
  - EXEC: alu_* are stable for the whole cycle. At the edge: res_data <= alu_out, res_carry <= alu_carry, res_err <= 0, res_valid <= 1; next state HOLD.
  - HOLD: res_valid = 1, and outputs stay stable until res_ready.
    - On res_ready: res_valid <= 0. If res_err = 0, acc <= res_data; an erroneous result leaves acc unchanged.
    - In the same edge, if FIFO is not empty, pop the head as in IDLE (to EXEC or HOLD); otherwise go to IDLE.
- Latency:
  - Command accepted in cycle t into an empty, idle block: legal op gives res_valid in cycle t+3; illegal op gives res_valid in cycle t+2.
  - With res_ready held high: one legal result every 2 cycles.
- Accumulator:
  - acc is WIDTH bits and is never exposed directly.
  - acc_flag is sampled at pop time, so it uses the acc value current at that edge, which includes a result consumed in the same edge.
- Arithmetic: the block does no arithmetic and wraps nothing. res_data and res_carry are exactly the ALU values sampled at the EXEC edge.
- The ALU must never see an illegal opcode: alu_op only ever holds 000-100.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_ADD = 3'd0, OP_SUB = 3'd1, OP_XOR = 3'd2, OP_OR = 3'd3, OP_AND = 3'd4, OP_LAST = OP_AND;
  - the opcode width constant;
  - the FSM state enum {IDLE, EXEC, HOLD}.
- One sub-module: alu_cmd_fifo.
  - Synchronous FIFO with parameters WIDTH and DEPTH.
  - Packs the {op, a, b, acc} entry.
  - Outputs full, empty and level.
  - Uses the same clk and rst.

Test Plan:
- Add: ADD a=0x3C b=0x05, res_ready=1, real ALU attached -> res_valid in cycle t+3, res_data=0x41, res_err=0, res_carry equals alu_carry during EXEC.
- Sub with wrap: SUB a=0x10 b=0x20 -> res_data=0xF0, res_err=0.
- Accumulate: after the 0x41 result is consumed, ADD cmd_acc=1 b=0x01 (cmd_a=0xFF ignored) -> alu_a=0x41, res_data=0x42. Then AND cmd_acc=1 b=0x0F -> 0x02.
- Illegal opcode: op=3'b110 a=0x12 b=0x34 -> res_valid at t+2, res_data=0x00, res_err=1, alu_op unchanged. A following acc ADD b=0 returns the previous acc value.
- Backpressure/full: res_ready=0, cmd_valid=1 with 6 distinct commands -> 5 accepted (1 held in HOLD, 4 in FIFO), cmd_ready=0 and cmd_level=4. Then res_ready=1 -> all 5 results emerge in order, one per 2 cycles, and cmd_ready returns 1.
- Reset mid-operation: assert rst for 1 cycle while in EXEC with 2 commands queued -> next cycle res_valid=0, cmd_level=0, alu_op=000, acc=0. No stale results appear afterwards.
